doodle_motion_ctrl: RTL
=======================

Name: doodle_motion_ctrl

Overview:
- Frame-rate motion sequencer for the doodle.
- Tracks the one-hot phase outputs of the doodle jump state machine (I/Up/Down/Done) and generates the signals that machine consumes: doodle position (object_x, object_y), jump progress (up_count) and screen scroll offset.
- Sits between the VGA frame timing and the jump state machine. Updates once per frame tick and freezes on game over.

Parameters:
- JUMP_HEIGHT, 120, saturation limit for up_count; must match the value driven to the jump state machine
- V_STEP, 2, vertical pixels moved per frame tick
- H_STEP, 3, horizontal pixels moved per frame tick
- X_START, 459, reset/idle object_x (screen horizontal middle including the 144 offset)
- Y_START, 485, reset/idle object_y
- X_MIN, 157, left clamp for object_x (144 + doodle radius 13)
- X_MAX, 761, right clamp for object_x (774 - 13)
- V_MIDDLE, 275, upper limit for object_y; above this the view scrolls instead
- Y_FLOOR, 530, lower clamp for object_y

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (end of vertical active)
- q_I  in  1  jump state machine idle
- q_Up  in  1  jump state machine rising
- q_Down  in  1  jump state machine falling
- q_Done  in  1  jump state machine game over
- btn_left  in  1  synchronized, level move-left request
- btn_right  in  1  synchronized, level move-right request
- object_x  out  10  doodle centre x
- object_y  out  10  doodle centre y
- up_count  out  10  pixels climbed in the current jump
- scroll  out  10  accumulated scroll offset
- land_pulse  out  1  one-cycle pulse when a new jump begins
- sm_err  out  1  sticky flag: illegal phase encoding seen

Behaviour:
- Reset (asynchronous, any time including mid-jump) values:
  - object_x = X_START, object_y = Y_START
  - up_count = 0, scroll = 0
  - land_pulse = 0, sm_err = 0
  - internal phase = WAIT
- Internal phase FSM (WAIT, RISE, FALL, HALT) is re-evaluated every Clk, not only on tick, from the q_* inputs:
  - q_I -> WAIT; q_Up -> RISE; q_Down -> FALL; q_Done -> HALT.
  - Zero or multiple q_* bits high -> HALT and sm_err <= 1. sm_err is cleared only by Reset.
- Jump start:
  - Phase moving from WAIT or FALL into RISE: up_count <= 0 and land_pulse = 1 for exactly that cycle.
  - RISE -> RISE never pulses.
- Frame-tick updates use the phase register value before that edge (the old phase). All outputs are registered, so an update is visible in the cycle after the tick. With no tick, all positions hold.
- RISE on tick:
  - up_count <= min(up_count + V_STEP, JUMP_HEIGHT).
  - If object_y - V_STEP < V_MIDDLE: object_y <= V_MIDDLE and scroll <= min(scroll + V_STEP, 1023).
  - Otherwise object_y <= object_y - V_STEP and scroll holds.
- FALL on tick:
  - object_y <= min(object_y + V_STEP, Y_FLOOR).
  - up_count and scroll hold.
- RISE or FALL on tick, horizontal:
  - btn_left only: object_x <= max(object_x - H_STEP, X_MIN).
  - btn_right only: object_x <= min(object_x + H_STEP, X_MAX).
  - Both or neither: object_x holds.
- WAIT: object_x, object_y, up_count and scroll are forced to their reset values every cycle.
- HALT: all outputs frozen, ticks ignored. Leaving HALT requires Reset or q_I (which passes through WAIT).
- Tick in the same cycle as a phase change:
  - Motion is computed with the old phase.
  - The jump-start clear of up_count has priority over a RISE increment.
- Arithmetic:
  - All 10-bit unsigned; clamps are computed without intermediate wrap (use 11-bit compares).
  - No output ever wraps.

Test Plan:
- Reset held, then q_I=1 for 10 ticks -> object_x=459, object_y=485, up_count=0, scroll=0, land_pulse=0.
- q_I->q_Up, then 5 ticks -> one land_pulse on the transition cycle; after 5 ticks up_count=10, object_y=475.
- RISE with object_y=277 and V_STEP=2, 3 ticks -> object_y=275 held, scroll=4. Then 60 more ticks -> up_count saturates at 120.
- FALL with btn_left held, x=160 -> x clamps at 157. Both buttons held -> x unchanged. object_y reaches Y_FLOOR 530 and holds.
- q_Down->q_Up in the same cycle as frame_tick with up_count=40 -> up_count=0 next cycle, land_pulse=1, object_y moved by +2 (FALL motion used).
- q_Up=q_Down=1 -> sm_err=1, outputs frozen, sm_err persists until Reset. Reset asserted mid-RISE -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/doodle_motion_ctrl.sv
// Per-frame doodle motion sequencer that follows the jump FSM phase (I/Up/Down/Done) and drives position, jump progress and scroll.
// Registered outputs, visible one cycle after a frame tick; no backpressure, and the outputs freeze while the phase is game over.
module doodle_motion_ctrl #(
  parameter int JUMP_HEIGHT = 120,
  parameter int V_STEP      = 2,
  parameter int H_STEP      = 3,
  parameter int X_START     = 459,
  parameter int Y_START     = 485,
  parameter int X_MIN       = 157,
  parameter int X_MAX       = 761,
  parameter int V_MIDDLE    = 275,
  parameter int Y_FLOOR     = 530
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       q_I,
  input  logic       q_Up,
  input  logic       q_Down,
  input  logic       q_Done,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] object_x,
  output logic [9:0] object_y,
  output logic [9:0] up_count,
  output logic [9:0] scroll,
  output logic       land_pulse,
  output logic       sm_err
);

  localparam logic [9:0]  C_X_START = 10'(X_START);
  localparam logic [9:0]  C_Y_START = 10'(Y_START);
  localparam logic [9:0]  C_X_MIN   = 10'(X_MIN);
  localparam logic [9:0]  C_X_MAX   = 10'(X_MAX);
  localparam logic [9:0]  C_V_MID   = 10'(V_MIDDLE);
  localparam logic [9:0]  C_Y_FLOOR = 10'(Y_FLOOR);
  localparam logic [9:0]  C_JH      = 10'(JUMP_HEIGHT);
  localparam logic [9:0]  C_V_STEP  = 10'(V_STEP);
  localparam logic [9:0]  C_H_STEP  = 10'(H_STEP);
  localparam logic [9:0]  C_MAX10   = 10'd1023;
  localparam logic [10:0] E_X_MIN   = 11'(X_MIN);
  localparam logic [10:0] E_X_MAX   = 11'(X_MAX);
  localparam logic [10:0] E_V_MID   = 11'(V_MIDDLE);
  localparam logic [10:0] E_Y_FLOOR = 11'(Y_FLOOR);
  localparam logic [10:0] E_JH      = 11'(JUMP_HEIGHT);
  localparam logic [10:0] E_V_STEP  = 11'(V_STEP);
  localparam logic [10:0] E_H_STEP  = 11'(H_STEP);
  localparam logic [10:0] E_MAX10   = 11'd1023;

  typedef enum logic [1:0] {P_WAIT = 2'd0, P_RISE = 2'd1, P_FALL = 2'd2, P_HALT = 2'd3} phase_t;

  phase_t     r_phase, w_phase_nxt;
  logic       w_illegal, w_jump_start;
  logic [9:0] r_x, r_y, r_up, r_scroll;
  logic       r_land, r_err;
  logic [9:0] w_x_mv, w_y_rise, w_y_fall, w_up_rise, w_scroll_rise;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_phase <= P_WAIT;
    else       r_phase <= w_phase_nxt;
  end

  // Anything other than exactly one phase bit is treated as a broken FSM and parks us in HALT.
  always_comb begin
    w_phase_nxt = P_HALT;
    w_illegal   = 1'b0;
    case ({q_I, q_Up, q_Down, q_Done})
      4'b1000: w_phase_nxt = P_WAIT;
      4'b0100: w_phase_nxt = P_RISE;
      4'b0010: w_phase_nxt = P_FALL;
      4'b0001: w_phase_nxt = P_HALT;
      default: w_illegal   = 1'b1;
    endcase
  end

  assign w_jump_start = (w_phase_nxt == P_RISE) && ((r_phase == P_WAIT) || (r_phase == P_FALL));

  // Clamps compare in 11 bits so a step past either screen edge can never wrap.
  always_comb begin
    w_x_mv = r_x;
    if (btn_left && !btn_right)
      w_x_mv = ({1'b0, r_x} < E_X_MIN + E_H_STEP) ? C_X_MIN : r_x - C_H_STEP;
    else if (btn_right && !btn_left)
      w_x_mv = ({1'b0, r_x} + E_H_STEP > E_X_MAX) ? C_X_MAX : r_x + C_H_STEP;

    w_up_rise = ({1'b0, r_up} + E_V_STEP > E_JH) ? C_JH : r_up + C_V_STEP;
    w_y_fall  = ({1'b0, r_y} + E_V_STEP > E_Y_FLOOR) ? C_Y_FLOOR : r_y + C_V_STEP;

    if ({1'b0, r_y} < E_V_MID + E_V_STEP) begin
      w_y_rise      = C_V_MID;
      w_scroll_rise = ({1'b0, r_scroll} + E_V_STEP > E_MAX10) ? C_MAX10 : r_scroll + C_V_STEP;
    end else begin
      w_y_rise      = r_y - C_V_STEP;
      w_scroll_rise = r_scroll;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x      <= C_X_START;
      r_y      <= C_Y_START;
      r_up     <= '0;
      r_scroll <= '0;
      r_land   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_land <= w_jump_start;
      if (w_illegal) r_err <= 1'b1;
      if (r_phase == P_WAIT) begin
        r_x      <= C_X_START;
        r_y      <= C_Y_START;
        r_up     <= '0;
        r_scroll <= '0;
      end else if (frame_tick && (r_phase != P_HALT)) begin
        r_x <= w_x_mv;
        if (r_phase == P_RISE) begin
          r_y      <= w_y_rise;
          r_up     <= w_up_rise;
          r_scroll <= w_scroll_rise;
        end else begin
          r_y <= w_y_fall;
        end
      end
      // A new jump always restarts the climb count, even if a rise step landed this edge.
      if (w_jump_start) r_up <= '0;
    end
  end

  assign object_x   = r_x;
  assign object_y   = r_y;
  assign up_count   = r_up;
  assign scroll     = r_scroll;
  assign land_pulse = r_land;
  assign sm_err     = r_err;

endmodule
